// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// A terminal count T gives a half period of T+1 board-clock cycles.
package clk_div_pkg;

    localparam int unsigned CLK_HZ            = 100_000_000;
    localparam int unsigned DEFAULT_HALF_1KHZ = 49999;

    function automatic int unsigned half_for_hz(input int unsigned hz);
        return CLK_HZ / (2 * hz) - 1;
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: counts up to term, toggles clk_out on wrap, applies a pended term at the wrap.
// When CLK_DIV_SYNC_EN is defined, a sync input restarts the channel like a disable.
module clk_div_ch #(
    parameter int unsigned CNT_W        = 29,
    parameter int unsigned DEFAULT_HALF = 49999
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef CLK_DIV_SYNC_EN
    input  logic             sync,
`endif
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             pend_vld,
    output logic             clk_out,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] term;
    logic [CNT_W-1:0] pend;
    logic             restart;

`ifdef CLK_DIV_SYNC_EN
    assign restart = sync | ~en;
`else
    assign restart = ~en;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            term     <= CNT_W'(DEFAULT_HALF);
            pend     <= '0;
            pend_vld <= 1'b0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
        end else begin
            if (restart) begin
                cnt     <= '0;
                clk_out <= 1'b0;
                tick    <= 1'b0;
                if (pend_vld) begin
                    term     <= pend;
                    pend_vld <= 1'b0;
                end
            end else if (cnt == term) begin
                cnt     <= '0;
                clk_out <= ~clk_out;
                tick    <= ~clk_out;
                if (pend_vld) begin
                    term     <= pend;
                    pend_vld <= 1'b0;
                end
            end else begin
                cnt  <= cnt + 1'b1;
                tick <= 1'b0;
            end
            // load is only granted while pend_vld is clear, so it never collides with an apply
            if (load) begin
                pend     <= load_val;
                pend_vld <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider / tick generator with a valid/ready reload port.
// Define CLK_DIV_SYNC_EN to add a sync input that phase-aligns all channels.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter  int unsigned NUM_CH       = 4,
    parameter  int unsigned CNT_W        = 29,
    parameter  int unsigned DEFAULT_HALF = DEFAULT_HALF_1KHZ,
    localparam int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_100mhz,
    input  logic              rst_n,
`ifdef CLK_DIV_SYNC_EN
    input  logic              sync,
`endif
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    logic [NUM_CH-1:0] hit;
    logic [NUM_CH-1:0] load;
    logic [NUM_CH-1:0] pend_vld;

    // Out-of-range channels hit nothing, so ready stays high and the request is dropped.
    always_comb begin
        hit       = '0;
        cfg_ready = 1'b1;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                hit[i]    = 1'b1;
                cfg_ready = ~pend_vld[i];
            end
        end
    end

    assign load = hit & {NUM_CH{cfg_valid & cfg_ready}};

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_valid & ~(|hit);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_ch #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_ch (
            .clk      (clk_100mhz),
            .rst_n    (rst_n),
`ifdef CLK_DIV_SYNC_EN
            .sync     (sync),
`endif
            .en       (ch_en[i]),
            .load     (load[i]),
            .load_val (cfg_half),
            .pend_vld (pend_vld[i]),
            .clk_out  (clk_out[i]),
            .tick     (tick[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: a countdown model checked every cycle plus directed literal checks.
// A second NUM_CH=3 instance covers the out-of-range config path.
module tb_clk_div_multi;

    localparam int unsigned NCH = 4;
    localparam int unsigned CW  = 8;
    localparam int unsigned DH  = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] ch_en;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [1:0]     cfg_ch;
    logic [CW-1:0]  cfg_half;
    logic           cfg_err;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;

    logic [2:0]     ch_en3;
    logic           cfg_valid3;
    logic           cfg_ready3;
    logic [1:0]     cfg_ch3;
    logic [CW-1:0]  cfg_half3;
    logic           cfg_err3;
    logic [2:0]     clk_out3;
    logic [2:0]     tick3;
`ifdef CLK_DIV_SYNC_EN
    logic           sync;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    clk_div_multi #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_HALF(DH)) dut (
        .clk_100mhz (clk),
        .rst_n      (rst_n),
`ifdef CLK_DIV_SYNC_EN
        .sync       (sync),
`endif
        .ch_en      (ch_en),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_half   (cfg_half),
        .cfg_err    (cfg_err),
        .clk_out    (clk_out),
        .tick       (tick)
    );

    clk_div_multi #(.NUM_CH(3), .CNT_W(CW), .DEFAULT_HALF(DH)) dut3 (
        .clk_100mhz (clk),
        .rst_n      (rst_n),
`ifdef CLK_DIV_SYNC_EN
        .sync       (sync),
`endif
        .ch_en      (ch_en3),
        .cfg_valid  (cfg_valid3),
        .cfg_ready  (cfg_ready3),
        .cfg_ch     (cfg_ch3),
        .cfg_half   (cfg_half3),
        .cfg_err    (cfg_err3),
        .clk_out    (clk_out3),
        .tick       (tick3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: per channel, cycles left in the current half period (countdown), output level and pending reload.
    int unsigned m_rem  [NCH];
    int unsigned m_term [NCH];
    int unsigned m_pend [NCH];
    bit          m_pv   [NCH];
    bit          m_lvl  [NCH];
    bit          m_tick [NCH];
    bit          m_err;
    int unsigned m3;
    bit          m3_err;

    function automatic bit model_ready();
        return (int'(cfg_ch) >= int'(NCH)) ? 1'b1 : !m_pv[cfg_ch];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NCH); i++) begin
                m_term[i] = DH;
                m_rem[i]  = DH + 1;
                m_pend[i] = 0;
                m_pv[i]   = 1'b0;
                m_lvl[i]  = 1'b0;
                m_tick[i] = 1'b0;
            end
            m_err  = 1'b0;
            m3     = 0;
            m3_err = 1'b0;
        end else begin
            bit xfer;
            bit rs;
            int unsigned tch;
            xfer  = cfg_valid && model_ready();
            tch   = cfg_ch;
            m_err = xfer && (tch >= NCH);
            for (int i = 0; i < int'(NCH); i++) begin
`ifdef CLK_DIV_SYNC_EN
                rs = !ch_en[i] || sync;
`else
                rs = !ch_en[i];
`endif
                if (rs || m_rem[i] == 1) begin
                    if (m_pv[i]) begin
                        m_term[i] = m_pend[i];
                        m_pv[i]   = 1'b0;
                    end
                    m_tick[i] = !rs && !m_lvl[i];
                    m_lvl[i]  = !rs && !m_lvl[i];
                    m_rem[i]  = m_term[i] + 1;
                end else begin
                    m_rem[i]  = m_rem[i] - 1;
                    m_tick[i] = 1'b0;
                end
            end
            if (xfer && tch < NCH) begin
                m_pend[tch] = cfg_half;
                m_pv[tch]   = 1'b1;
            end
            // second instance: ch0 free-runs at T=DH, so its state is a closed form of enabled edges
`ifdef CLK_DIV_SYNC_EN
            m3 = (ch_en3[0] && !sync) ? m3 + 1 : 0;
`else
            m3 = ch_en3[0] ? m3 + 1 : 0;
`endif
            m3_err = cfg_valid3 && (cfg_ch3 == 2'd3);
        end
    end

    always @(negedge clk) begin
        logic [NCH-1:0] e_clk;
        logic [NCH-1:0] e_tick;
        for (int i = 0; i < int'(NCH); i++) begin
            e_clk[i]  = m_lvl[i];
            e_tick[i] = m_tick[i];
        end
        chk("clk_out", 32'(clk_out), 32'(e_clk));
        chk("tick", 32'(tick), 32'(e_tick));
        chk("cfg_err", 32'(cfg_err), 32'(m_err));
        chk("cfg_ready", 32'(cfg_ready), 32'(model_ready()));
        chk("clk_out3", 32'(clk_out3), {31'd0, ((m3 / (DH + 1)) % 2) == 1});
        chk("tick3", 32'(tick3), {31'd0, (m3 % (2 * (DH + 1))) == DH + 1});
        chk("cfg_err3", 32'(cfg_err3), 32'(m3_err));
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_until(input int ch, input logic lvl, output int n);
        n = 0;
        while (clk_out[ch] !== lvl && n < 64) begin
            cyc(1);
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ticks;
        rst_n      = 1'b0;
        ch_en      = '0;
        cfg_valid  = 1'b0;
        cfg_ch     = '0;
        cfg_half   = '0;
        ch_en3     = '0;
        cfg_valid3 = 1'b0;
        cfg_ch3    = '0;
        cfg_half3  = '0;
`ifdef CLK_DIV_SYNC_EN
        sync       = 1'b0;
`endif
        cyc(3);
        chk("rst_clk_out", 32'(clk_out), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        rst_n = 1'b1;
        cyc(1);

        // ch0 at the default T=4: first rise after 5 enabled edges, 5-cycle halves
        ch_en  = 4'b0001;
        ch_en3 = 3'b001;
        run_until(0, 1'b1, n);
        chk("ch0_first_rise", 32'(n), 32'd5);
        chk("ch0_tick_at_rise", 32'(tick[0]), 32'd1);
        run_until(0, 1'b0, n);
        chk("ch0_high_len", 32'(n), 32'd5);
        run_until(0, 1'b1, n);
        chk("ch0_low_len", 32'(n), 32'd5);
        chk("others_idle", 32'(clk_out[3:1]), 32'd0);

        // reload ch1 to T=1 two cycles into its first half period
        ch_en = 4'b0011;
        cyc(2);
        cfg_ch    = 2'd1;
        cfg_half  = 8'd1;
        cfg_valid = 1'b1;
        chk("ch1_ready_idle", 32'(cfg_ready), 32'd1);
        cyc(1);
        cfg_valid = 1'b0;
        chk("ch1_ready_pending", 32'(cfg_ready), 32'd0);
        run_until(1, 1'b1, n);
        chk("ch1_old_half_done", 32'(n), 32'd2);
        chk("ch1_ready_after_wrap", 32'(cfg_ready), 32'd1);
        run_until(1, 1'b0, n);
        chk("ch1_new_high_len", 32'(n), 32'd2);
        run_until(1, 1'b1, n);
        chk("ch1_new_low_len", 32'(n), 32'd2);

        // ch2 T=0 written while disabled, then enabled: toggles every cycle
        cfg_ch    = 2'd2;
        cfg_half  = 8'd0;
        cfg_valid = 1'b1;
        cyc(1);
        cfg_valid = 1'b0;
        cyc(1);
        ch_en[2] = 1'b1;
        ticks = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (i == 0) chk("ch2_first_edge_high", 32'(clk_out[2]), 32'd1);
            if (tick[2]) ticks++;
        end
        chk("ch2_tick_count", 32'(ticks), 32'd5);

        // out-of-range channel on the 3-channel instance
        cfg_ch3    = 2'd3;
        cfg_half3  = 8'd0;
        cfg_valid3 = 1'b1;
        #1;
        chk("oor_ready", 32'(cfg_ready3), 32'd1);
        cyc(1);
        cfg_valid3 = 1'b0;
        chk("oor_err_pulse", 32'(cfg_err3), 32'd1);
        cyc(1);
        chk("oor_err_clear", 32'(cfg_err3), 32'd0);
        cyc(12);

        // abort ch0 in its high phase, then restart
        run_until(0, 1'b1, n);
        cyc(2);
        ch_en[0] = 1'b0;
        cyc(1);
        chk("ch0_low_after_disable", 32'(clk_out[0]), 32'd0);
        ch_en[0] = 1'b1;
        run_until(0, 1'b1, n);
        chk("ch0_restart_rise", 32'(n), 32'd5);

        // asynchronous reset mid-period with ch3 running
        ch_en[3] = 1'b1;
        cyc(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_clk_out", 32'(clk_out), 32'd0);
        chk("async_rst_tick", 32'(tick), 32'd0);
        chk("async_rst_clk_out3", 32'(clk_out3), 32'd0);
        cyc(2);
        rst_n = 1'b1;
        run_until(1, 1'b1, n);
        chk("ch1_term_back_to_default", 32'(n), 32'd5);
        cyc(7);

`ifdef CLK_DIV_SYNC_EN
        // ch1 reloaded to T=2 while running offset from ch0, then phase-aligned by sync
        cfg_ch    = 2'd1;
        cfg_half  = 8'd2;
        cfg_valid = 1'b1;
        cyc(1);
        cfg_valid = 1'b0;
        cyc(4);
        sync = 1'b1;
        cyc(1);
        sync = 1'b0;
        chk("sync_low", 32'(clk_out[1:0]), 32'd0);
        run_until(1, 1'b1, n);
        chk("sync_ch1_rise", 32'(n), 32'd3);
        run_until(0, 1'b1, ticks);
        chk("sync_ch0_rise", 32'(n + ticks), 32'd5);
        cyc(10);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Multi-channel programmable clock divider and tick generator running on the 100 MHz board clock. Each of NUM_CH channels produces a 50 %-duty square wave and a one-cycle rising-edge tick. Each channel's half-period is reloadable at run time through a valid/ready config port, and a reload takes effect glitch-free at the channel's next toggle. It feeds display multiplexing, debouncers and timers with slow enables.

## Interface
- NUM_CH, 4: number of independent channels.
- CNT_W, 29: counter and terminal-count width.
- DEFAULT_HALF, 49999: reset terminal count for every channel (1 kHz at 100 MHz).
- CH_W, $clog2(NUM_CH) (min 1): channel-index width (localparam).

- clk_100mhz  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- ch_en  in  NUM_CH  per-channel run enable.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config accept (combinational).
- cfg_ch  in  CH_W  target channel.
- cfg_half  in  CNT_W  new terminal count T; half period = T+1 cycles.
- cfg_err  out  1  one-cycle pulse: accepted request had cfg_ch >= NUM_CH.
- clk_out  out  NUM_CH  divided clocks, f = 100 MHz / (2·(T+1)).
- tick  out  NUM_CH  one-cycle pulse coincident with each 0→1 of clk_out.

## Operation
- Per channel state: cnt[CNT_W], term[CNT_W], pend[CNT_W], pend_vld, clk_out, tick.
- Reset values: cnt=0, term=DEFAULT_HALF, pend_vld=0, clk_out=0, tick=0, cfg_err=0. Reset is immediate on rst_n low, including mid-period.
- Enabled edge (ch_en[i]=1):
  - cnt==term: cnt←0, clk_out toggles. tick←1 iff clk_out was 0. If pend_vld: term←pend, pend_vld←0.
  - Otherwise: cnt←cnt+1, tick←0.
- Disabled edge (ch_en[i]=0): cnt←0, clk_out←0, tick←0. A pending value is applied immediately (term←pend, pend_vld←0).
- Config handshake:
  - cfg_ready = ~pend_vld[cfg_ch] for in-range cfg_ch; 1 for out-of-range cfg_ch.
  - Transfer on cfg_valid & cfg_ready.
  - In range: pend←cfg_half, pend_vld←1.
  - Out of range: request dropped, cfg_err←1 next cycle.
- Write and wrap in the same cycle on the same channel: the wrap uses the old term. The new value is pended and applied at the following wrap. Simultaneous pend/apply cannot occur because ready is low while pend_vld=1.
- cfg_half=0 is legal: toggle every cycle (50 MHz). cnt never exceeds term, so no overflow. A term smaller than the current cnt cannot occur because term changes only when cnt=0.
- Deasserting ch_en mid-period aborts the period. Reasserting restarts from cnt=0 with clk_out low.

## Timing
- All outputs registered except cfg_ready.
- With ch_en sampled high from edge k (cnt=0), clk_out first rises after edge k+T. It stays high T+1 cycles, then low T+1 cycles.
- tick is high exactly in the first cycle clk_out is high.
- A reload accepted at edge j applies at the first wrap after j. From that wrap onward, every half period is the new T+1.
- cfg_err pulses in the cycle after the dropped transfer.

## Configuration
- CLK_DIV_SYNC_EN defined: an extra input sync (1 bit) is present. When sync=1 at an edge, every channel sets cnt←0, clk_out←0 and tick←0, and applies any pending value. sync has priority over ch_en and wrap logic. This phase-aligns all channels.
- Not defined: no sync port and no alignment behaviour. Channels are aligned only by reset or by ch_en.

## Structure
- Package clk_div_pkg: CLK_HZ=100_000_000, DEFAULT_HALF_1KHZ=49999, and function half_for_hz(hz) returning CLK_HZ/(2·hz)-1.
- Sub-module clk_div_ch holds one channel (cnt/term/pend/clk_out/tick, plus sync under the macro). The top holds NUM_CH generate instances and the config decode, cfg_ready mux and cfg_err.

## Test plan
Bench parameters: NUM_CH=4, CNT_W=8, DEFAULT_HALF=4.
- Reset then ch_en=4'b0001 → clk_out[0] period 10 cycles at 50 % duty; first rise after 5 enabled edges; tick[0] one cycle per period; other channels stay 0.
- Write ch1 T=1 while ch1 running at T=4 → current half period finishes at 5 cycles, then 2-cycle halves. cfg_ready for ch1 stays low until that wrap.
- Write ch2 T=0 → clk_out[2] toggles every cycle; tick[2] high every other cycle.
- With NUM_CH=3, write cfg_ch=3 → cfg_ready=1, cfg_err pulses once, no channel changes.
- Drop ch_en[0] mid-high-phase, then rst_n low mid-period on ch3 → clk_out[0] low next edge and restarts from cnt=0 on re-enable. Reset forces all outputs 0 asynchronously and term back to 4.
- CLK_DIV_SYNC_EN: ch0 T=4 and ch1 T=2 running and offset, pulse sync → both low the next cycle; ch0 rises 5 edges and ch1 rises 3 edges after sync.
